led_bank_scheduler: RTL and testbench
=====================================

# led_bank_scheduler

Shares the red (10-LED) and green (8-LED) indicator banks between four requesters and drives them with a common PWM waveform. Each granted session owns exactly one bank for a programmed number of PWM frames, at a steady or breathing brightness. A short blanking gap follows each session. Sits between status/alarm sources and the board LED pins, replacing per-source PWM logic.

## Interface
- IN_HZ, 50_000_000, clock frequency (documentation only, used for default derivation)
- PWM_PERIOD, 50_000, clocks per PWM frame (1 kHz at IN_HZ); ≥ 10
- GAP_CYC, 1_000, blanking clocks between sessions; ≥ 1
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- req  in  4  request per requester; level, held until session ends
- req_bank  in  4  per requester: 1 = red bank, 0 = green bank
- req_breathe  in  4  per requester: 1 = triangle ramp, 0 = steady
- req_level  in  16  4 bits per requester ([4i+3:4i]); duty in tenths, values >10 clamp to 10
- req_frames  in  32  8 bits per requester; session length in PWM frames, 0 treated as 1
- gnt  out  4  one-hot, one-cycle pulse on acceptance
- active  out  4  one-hot owner of the banks; 0 when idle/gap
- done  out  1  one-cycle pulse when a session ends (expiry or abort)
- led_red  out  10  red bank, all bits identical
- led_green  out  8  green bank, all bits identical

## Operation
- States: IDLE, RUN, GAP.
- IDLE: LEDs off. If any req bit is set, choose a winner round-robin, starting at rr_ptr and searching upward mod 4. Latch that requester's bank, breathe, level (clamped), and frames (0→1). Go to RUN with gnt[w]=1 and active[w]=1. Clear pwm_cnt and frame_cnt.
- Parameters are latched at grant. Changes to req_* during a session are ignored.
- RUN:
  - pwm_cnt counts 0..PWM_PERIOD-1 and wraps; frame_cnt increments on each wrap.
  - Duty step STEP = PWM_PERIOD/10 (integer). The selected bank is high when pwm_cnt < eff_level*STEP.
  - eff_level 10 forces full-on, whatever the remainder of PWM_PERIOD/10. eff_level 0 forces off.
  - The unselected bank stays 0.
  - Steady mode: eff_level = latched level.
  - Breathe mode: eff_level starts at 0, +1 per frame up to level, then −1 per frame down to 0, repeating (period 2·level frames). level 0 stays off.
  - Expiry: at the wrap ending frame frames−1, go to GAP and pulse done.
  - Abort: if req[owner] is low in any RUN cycle, go to GAP on the next edge and pulse done.
- GAP: all LEDs 0, active=0. Hold for GAP_CYC clocks, then go to IDLE. rr_ptr = owner+1 mod 4, updated on entry to GAP.
- Counter widths: pwm_cnt is $clog2(PWM_PERIOD) bits. The threshold is computed at $clog2(PWM_PERIOD+1) bits with no overflow. frame_cnt is 8 bits.

## Timing
- Reset (rst high at an edge): state=IDLE, rr_ptr=0, gnt=0, active=0, done=0, led_red=0, led_green=0, counters=0. All outputs are 0 from the cycle after the edge.
- A reset during RUN or GAP ends the session with no done pulse.
- Grant latency: req sampled high in IDLE at edge k → gnt/active high after edge k. The bank's first PWM high cycle also follows edge k, if eff_level>0.
- LED outputs are registered. The output follows pwm_cnt with one-cycle latency, with a constant phase.
- Session length on expiry: active is high for exactly frames·PWM_PERIOD cycles. done and the GAP transition coincide with active falling.
- Abort latency: req[owner] low sampled at edge k → active=0, LEDs=0, and done=1 after edge k.
- Idle-to-grant minimum spacing between sessions: GAP_CYC cycles of LEDs off, plus 1 IDLE cycle.
- Simultaneous requests: only one grant per IDLE cycle. The remaining requesters stay pending.
- A requester whose req is still high after its own session becomes eligible again only after the round-robin pass.

## Test plan
Benches use PWM_PERIOD=100 and GAP_CYC=4.
- Reset mid-RUN: assert rst during the second frame → all outputs 0 next cycle, no done pulse. A subsequent req[0] is granted with rr_ptr=0.
- Single steady: req[2], bank=red, level=3, frames=2 → gnt[2] pulses 1 cycle later. led_red is all-ones for 30 of every 100 cycles, and led_green stays 0. active lasts 200 cycles, then done, 4 gap cycles, IDLE.
- Clamp/limits: level=15 → full-on for the whole session; level=0 → off for the whole session; frames=0 → behaves as 1 frame (100 cycles).
- Round-robin: req=4'b1111 held → grants in order 0,1,2,3,0. Each grant is separated by session + 5 cycles.
- Abort: drop req[1] 37 cycles into its session → active=0, LEDs=0, and done=1 on the next cycle, then the gap, then the next requester is granted.
- Breathe: bank=green, level=2, frames=6 → per-frame duty 0,10,20,10,0,10 %. led_red stays 0 throughout.

Source files
------------

// File: rtl/led_bank_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : led_bank_scheduler
//  Purpose  : Round-robin arbiter that lends the red (10) or green (8) LED
//             bank to one of four requesters for a number of PWM frames,
//             at steady or breathing brightness, with a blanking gap after.
//  Revision : 1.0  initial release
// ============================================================================
module led_bank_scheduler #(
    parameter int IN_HZ      = 50_000_000,
    parameter int PWM_PERIOD = IN_HZ / 1_000,
    parameter int GAP_CYC    = IN_HZ / 50_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [3:0]  req_bank,
    input  logic [3:0]  req_breathe,
    input  logic [15:0] req_level,
    input  logic [31:0] req_frames,
    output logic [3:0]  gnt,
    output logic [3:0]  active,
    output logic        done,
    output logic [9:0]  led_red,
    output logic [7:0]  led_green
);

    localparam int c_pwm_w = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int c_thr_w = $clog2(PWM_PERIOD + 1);
    localparam int c_gap_w = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int c_step  = PWM_PERIOD / 10;

    localparam logic [c_pwm_w-1:0] c_pwm_last = c_pwm_w'(PWM_PERIOD - 1);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_CYC - 1);
    localparam logic [c_thr_w-1:0] c_thr_full = c_thr_w'(PWM_PERIOD);
    localparam logic [c_thr_w-1:0] c_thr_step = c_thr_w'(c_step);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [1:0]         r_rr_ptr;
    logic [1:0]         r_owner;
    logic               r_bank;
    logic               r_breathe;
    logic               r_dir_down;
    logic [3:0]         r_level;
    logic [3:0]         r_eff;
    logic [7:0]         r_frames;
    logic [7:0]         r_frame_cnt;
    logic [c_pwm_w-1:0] r_pwm_cnt;
    logic [c_gap_w-1:0] r_gap_cnt;

    logic               w_found;
    logic               w_grant;
    logic               w_end;
    logic               w_wrap;
    logic [1:0]         w_win;
    logic [1:0]         w_idx;
    logic [3:0]         w_lvl_raw;
    logic [3:0]         w_lvl_clamp;
    logic [3:0]         w_eff_next;
    logic [7:0]         w_frm_raw;
    logic [7:0]         w_frm_fix;
    logic [7:0]         w_frame_next;
    logic               w_dir_next;
    logic               w_bank_next;
    logic               w_led_on;
    logic [c_pwm_w-1:0] w_pwm_next;
    logic [c_thr_w-1:0] w_thr;

    // Round-robin search: first requester at or above rr_ptr, wrapping mod 4
    always_comb begin
        w_found = 1'b0;
        w_win   = r_rr_ptr;
        w_idx   = r_rr_ptr;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_rr_ptr + 2'(i);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Winner's level clamped to 10 and frame count with 0 promoted to 1
    assign w_lvl_raw   = req_level[{w_win, 2'b00} +: 4];
    assign w_lvl_clamp = (w_lvl_raw > 4'd10) ? 4'd10 : w_lvl_raw;
    assign w_frm_raw   = req_frames[{w_win, 3'b000} +: 8];
    assign w_frm_fix   = (w_frm_raw == 8'd0) ? 8'd1 : w_frm_raw;
    assign w_wrap      = (r_pwm_cnt == c_pwm_last);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, counter and brightness sequencing
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_end        = 1'b0;
        w_pwm_next   = '0;
        w_frame_next = 8'd0;
        w_eff_next   = r_eff;
        w_dir_next   = r_dir_down;
        w_bank_next  = r_bank;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_next = S_RUN;
                    w_grant      = 1'b1;
                    w_bank_next  = req_bank[w_win];
                    w_eff_next   = req_breathe[w_win] ? 4'd0 : w_lvl_clamp;
                    w_dir_next   = 1'b0;
                end
            end
            S_RUN: begin
                if (!req[r_owner] || (w_wrap && (r_frame_cnt == r_frames - 8'd1))) begin
                    w_state_next = S_GAP;
                    w_end        = 1'b1;
                end else if (w_wrap) begin
                    w_frame_next = r_frame_cnt + 8'd1;
                    // Triangle ramp: climb to level, then fall back to 0
                    if (r_breathe && (r_level != 4'd0)) begin
                        if (r_dir_down) begin
                            w_eff_next = r_eff - 4'd1;
                            if (r_eff == 4'd1) begin
                                w_dir_next = 1'b0;
                            end
                        end else begin
                            w_eff_next = r_eff + 4'd1;
                            if ((r_eff + 4'd1) == r_level) begin
                                w_dir_next = 1'b1;
                            end
                        end
                    end
                end else begin
                    w_pwm_next   = r_pwm_cnt + 1'b1;
                    w_frame_next = r_frame_cnt;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == c_gap_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Level 10 is full-on regardless of PWM_PERIOD/10 rounding
    assign w_thr    = (w_eff_next >= 4'd10) ? c_thr_full
                                            : (c_thr_w'(w_eff_next) * c_thr_step);
    assign w_led_on = (w_state_next == S_RUN) && (c_thr_w'(w_pwm_next) < w_thr);

    // Session registers, registered outputs and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= 2'd0;
            r_owner     <= 2'd0;
            r_bank      <= 1'b0;
            r_breathe   <= 1'b0;
            r_dir_down  <= 1'b0;
            r_level     <= 4'd0;
            r_eff       <= 4'd0;
            r_frames    <= 8'd0;
            r_frame_cnt <= 8'd0;
            r_pwm_cnt   <= '0;
            r_gap_cnt   <= '0;
            gnt         <= 4'b0000;
            active      <= 4'b0000;
            done        <= 1'b0;
            led_red     <= 10'd0;
            led_green   <= 8'd0;
        end else begin
            gnt         <= w_grant ? (4'b0001 << w_win) : 4'b0000;
            done        <= w_end;
            led_red     <= {10{w_led_on & w_bank_next}};
            led_green   <= {8{w_led_on & ~w_bank_next}};
            r_pwm_cnt   <= w_pwm_next;
            r_frame_cnt <= w_frame_next;
            r_eff       <= w_eff_next;
            r_dir_down  <= w_dir_next;
            r_bank      <= w_bank_next;
            r_gap_cnt   <= ((r_state == S_GAP) && (w_state_next == S_GAP))
                           ? (r_gap_cnt + 1'b1) : '0;
            if (w_grant) begin
                r_owner   <= w_win;
                r_breathe <= req_breathe[w_win];
                r_level   <= w_lvl_clamp;
                r_frames  <= w_frm_fix;
                active    <= 4'b0001 << w_win;
            end else if (w_end) begin
                active   <= 4'b0000;
                r_rr_ptr <= r_owner + 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_bank_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_bank_scheduler
//  Purpose  : Directed self-checking bench for led_bank_scheduler
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_bank_scheduler;

    localparam int PER = 100;
    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  req_bank;
    logic [3:0]  req_breathe;
    logic [15:0] req_level;
    logic [31:0] req_frames;
    logic [3:0]  gnt;
    logic [3:0]  active;
    logic        done;
    logic [9:0]  led_red;
    logic [7:0]  led_green;

    int total = 0;
    int bad   = 0;
    int exp_thr [0:7];

    led_bank_scheduler #(
        .IN_HZ      (50_000_000),
        .PWM_PERIOD (PER),
        .GAP_CYC    (GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_bank    (req_bank),
        .req_breathe (req_breathe),
        .req_level   (req_level),
        .req_frames  (req_frames),
        .gnt         (gnt),
        .active      (active),
        .done        (done),
        .led_red     (led_red),
        .led_green   (led_green)
    );

    // 10-unit clock period
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int i, input bit bank, input bit br,
                           input logic [3:0] lvl, input logic [7:0] frm);
        req_bank[i]          = bank;
        req_breathe[i]       = br;
        req_level[4*i +: 4]  = lvl;
        req_frames[8*i +: 8] = frm;
    endtask

    task automatic set_thr(input int v);
        for (int k = 0; k < 8; k++) exp_thr[k] = v;
    endtask

    task automatic idle_gap(input string tag);
        repeat (6) @(negedge clk);
        check({tag, "_idle"}, {gnt, active, done, led_red, led_green}, 32'd0);
    endtask

    // Wait for the grant, then follow the session cycle by cycle.
    // exp_thr[f] is the number of lit cycles expected in frame f.
    task automatic watch(input int w, input bit red, input int len,
                         input int exp_wait, input bit drop, input string tag);
        int         n;
        int         errs;
        bit         on;
        logic [3:0] oh;
        oh = 4'b0001 << w;
        n  = 0;
        while (gnt === 4'b0000 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_wait"}, n, exp_wait);
        check({tag, "_gnt"}, gnt, oh);
        errs = 0;
        for (int c = 0; c < len; c++) begin
            on = (c % PER) < exp_thr[c / PER];
            if (active !== oh) errs++;
            if (done !== 1'b0) errs++;
            if (c > 0 && gnt !== 4'b0000) errs++;
            if (led_red !== {10{on & red}}) errs++;
            if (led_green !== {8{on & ~red}}) errs++;
            if (drop && c == len - 1) req[w] = 1'b0;
            @(negedge clk);
        end
        check({tag, "_body_errs"}, errs, 0);
        check({tag, "_end"}, {active, done, led_red, led_green}, {4'b0000, 1'b1, 18'd0});
    endtask

    initial begin
        rst         = 1'b1;
        req         = 4'b1111;
        req_bank    = 4'b0000;
        req_breathe = 4'b0000;
        req_level   = 16'd0;
        req_frames  = 32'd0;
        set_thr(0);

        // Reset state, with requests present
        repeat (3) @(negedge clk);
        check("rst_gnt", gnt, 4'b0000);
        check("rst_active", active, 4'b0000);
        check("rst_done", done, 1'b0);
        check("rst_red", led_red, 10'd0);
        check("rst_green", led_green, 8'd0);

        // Round-robin with clamp/limit configurations, all requests held
        set_cfg(0, 1'b1, 1'b0, 4'd15, 8'd1);
        set_cfg(1, 1'b0, 1'b0, 4'd0,  8'd1);
        set_cfg(2, 1'b0, 1'b0, 4'd5,  8'd0);
        set_cfg(3, 1'b1, 1'b0, 4'd10, 8'd1);
        rst = 1'b0;
        req = 4'b1111;
        set_thr(100); watch(0, 1'b1, 100, 1, 1'b0, "rr0_lvl15");
        set_thr(0);   watch(1, 1'b0, 100, 5, 1'b0, "rr1_lvl0");
        set_thr(50);  watch(2, 1'b0, 100, 5, 1'b0, "rr2_frm0");
        set_thr(100); watch(3, 1'b1, 100, 5, 1'b0, "rr3_lvl10");
        set_thr(100); watch(0, 1'b1, 100, 5, 1'b0, "rr0_again");
        req = 4'b0000;
        idle_gap("rr");

        // Single steady session: red, level 3, two frames
        set_cfg(2, 1'b1, 1'b0, 4'd3, 8'd2);
        set_thr(30);
        req = 4'b0100;
        watch(2, 1'b1, 200, 1, 1'b0, "steady");
        req = 4'b0000;
        idle_gap("steady");

        // Abort of requester 1, then requester 3 served after the gap
        set_cfg(1, 1'b0, 1'b0, 4'd7, 8'd3);
        set_cfg(3, 1'b1, 1'b0, 4'd4, 8'd1);
        req = 4'b0010;
        @(negedge clk);
        req[3] = 1'b1;
        set_thr(70); watch(1, 1'b0, 37, 0, 1'b1, "abort");
        set_thr(40); watch(3, 1'b1, 100, 5, 1'b0, "post_abort");
        req = 4'b0000;
        idle_gap("abort");

        // Breathing green, level 2, six frames: 0,10,20,10,0,10 %
        set_cfg(0, 1'b0, 1'b1, 4'd2, 8'd6);
        exp_thr[0] = 0;  exp_thr[1] = 10; exp_thr[2] = 20;
        exp_thr[3] = 10; exp_thr[4] = 0;  exp_thr[5] = 10;
        exp_thr[6] = 0;  exp_thr[7] = 0;
        req = 4'b0001;
        watch(0, 1'b0, 600, 1, 1'b0, "breathe");
        req = 4'b0000;
        idle_gap("breathe");

        // Reset in the second frame of a session
        set_cfg(1, 1'b1, 1'b0, 4'd5, 8'd3);
        req = 4'b0010;
        @(negedge clk);
        check("mid_gnt", gnt, 4'b0010);
        repeat (150) @(negedge clk);
        check("mid_active", active, 4'b0010);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_active", active, 4'b0000);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_leds", {led_red, led_green}, 18'd0);
        check("mid_rst_gnt", gnt, 4'b0000);
        // rr_ptr must be back at 0: requester 0 wins over requester 3
        set_cfg(0, 1'b1, 1'b0, 4'd10, 8'd1);
        set_cfg(3, 1'b0, 1'b0, 4'd10, 8'd1);
        rst = 1'b0;
        req = 4'b1001;
        set_thr(100);
        watch(0, 1'b1, 100, 1, 1'b0, "post_rst");
        req = 4'b0000;
        idle_gap("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
